// File: rtl/data_mem_bridge_if.sv
// Data-memory bus between the pipeline bridge (master) and the memory system (slave).
// Request fields are master-driven registers; the slave returns the accept/complete handshakes and the read data.
interface data_mem_bridge_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic          req;
    logic          wr;
    logic [SW-1:0] wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_mem_bridge.sv
// M-stage data-memory bridge: turns one load/store into a single addr/data bus transaction and stalls the pipeline meanwhile.
// Optional feature: define DMEM_ADDR_MAP_EN to fold kseg0/kseg1 addresses to physical addresses on the bus.
module data_mem_bridge (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memenM,
    input  logic [3:0]               memwriteM,
    input  logic [31:0]              aluoutM,
    input  logic [31:0]              writedataM,
    output logic [31:0]              readdataM,
    output logic                     stallM,
    data_mem_bridge_if.master        bus
);
    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   stall_c;
    logic   capture_c;

    // Virtual-to-physical fold applied once, when the request is latched.
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] a);
`ifdef DMEM_ADDR_MAP_EN
        if ((a[31:29] == 3'b100) || (a[31:29] == 3'b101)) begin
            return {3'b000, a[28:0]};
        end
        return a;
`else
        return a;
`endif
    endfunction

    // Next-state, stall and load-capture decode.
    always_comb begin
        state_d   = state_q;
        stall_c   = 1'b0;
        capture_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_c = memenM;
                if (memenM) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                stall_c = 1'b1;
                if (bus.addr_ok) begin
                    state_d   = bus.data_ok ? DONE : DATA;
                    capture_c = bus.data_ok & ~bus.wr;
                end
            end
            DATA: begin
                stall_c = 1'b1;
                if (bus.data_ok) begin
                    state_d   = DONE;
                    capture_c = ~bus.wr;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stallM = stall_c & ~rst;

    // State, latched request fields (which double as the bus outputs) and load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bus.req   <= 1'b0;
            bus.wr    <= 1'b0;
            bus.wstrb <= '0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            readdataM <= '0;
        end else begin
            state_q <= state_d;
            bus.req <= (state_d == ADDR);
            if ((state_q == IDLE) && memenM) begin
                bus.wr    <= |memwriteM;
                bus.wstrb <= memwriteM;
                bus.addr  <= map_addr(aluoutM);
                bus.wdata <= writedataM;
            end
            if (capture_c) begin
                readdataM <= bus.rdata;
            end
        end
    end
endmodule
